spi_reg_bank: RTL

- Parametrised SPI mode-0 peripheral with a register bank of NUM_REGS x DATA_W.
- Supports write and read frames: read data is returned on CIPO.
- Frame length and address range are validated, with error pulses on failure.
- All SPI inputs are synchronised into clk; the bank feeds PWM/output-enable logic and any other consumer.

---
 rtl/spi_reg_bank_if.sv | 12 +
 rtl/spi_reg_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle for spi_reg_bank: the controller drives the master side, the register bank
// uses the slave side.
interface spi_reg_bank_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a NUM_REGS x DATA_W register bank. The SPI pins are
// oversampled into clk, and a frame is committed in the cycle after chip-select is released.
module spi_reg_bank #(
    parameter int unsigned       NUM_REGS    = 5,
    parameter int unsigned       ADDR_W      = 7,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_q,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       rd_stb,
    output logic                       err_len,
    output logic                       err_addr
);
    localparam int unsigned CMD_W   = 1 + ADDR_W;
    localparam int unsigned FRAME_W = CMD_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RDATA = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES:0]   ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [CMD_W-1:0]  cmd_sr_q, cmd_sr_d, cmd_shift;
    logic [DATA_W-1:0] wdata_sr_q, wdata_sr_d;
    logic [DATA_W-1:0] sout_q, sout_d, rd_val;
    logic              cipo_oe_q, cipo_oe_d;
    logic              commit_q, commit_d;
    logic [DATA_W-1:0] bank_q [NUM_REGS];
    logic [DATA_W-1:0] bank_d [NUM_REGS];
    logic              wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
    logic              err_len_q, err_len_d, err_addr_q, err_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, commit_addr;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < NUM_REGS;
    endfunction

    // Edges compare the last synchroniser stage against one extra delayed copy.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], spi.sclk};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-1:0], spi.ncs};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
        sclk_rise   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
        sclk_fall   = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
        ncs_rise    = ncs_sync_q[SYNC_STAGES-1] & ~ncs_sync_q[SYNC_STAGES];
        ncs_fall    = ~ncs_sync_q[SYNC_STAGES-1] & ncs_sync_q[SYNC_STAGES];
        copi_s      = copi_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        cmd_shift   = {cmd_sr_q[CMD_W-2:0], copi_s};
        bit_cnt_inc = (bit_cnt_q == CNT_W'(FRAME_W + 1)) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
        commit_addr = cmd_sr_q[ADDR_W-1:0];
        rd_val      = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (cmd_shift[ADDR_W-1:0] == ADDR_W'(i)) rd_val = bank_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sr_d   = cmd_sr_q;
        wdata_sr_d = wdata_sr_q;
        sout_d     = sout_q;
        cipo_oe_d  = cipo_oe_q;
        commit_d   = 1'b0;
        bank_d     = bank_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        rd_stb_d   = 1'b0;
        err_len_d  = 1'b0;
        err_addr_d = 1'b0;

        // A chip-select release wins over any sclk edge seen in the same cycle.
        if (ncs_rise) begin
            state_d   = ST_IDLE;
            cipo_oe_d = 1'b0;
            commit_d  = (state_q != ST_IDLE);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_inc;
                        cmd_sr_d  = cmd_shift;
                        if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                            if (cmd_shift[CMD_W-1]) begin
                                state_d = ST_WDATA;
                            end else begin
                                state_d   = ST_RDATA;
                                sout_d    = rd_val;
                                rd_stb_d  = 1'b1;
                                cipo_oe_d = 1'b1;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d  = bit_cnt_inc;
                        wdata_sr_d = {wdata_sr_q[DATA_W-2:0], copi_s};
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) state_d = ST_DRAIN;
                    end
                end
                ST_RDATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_inc;
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) state_d = ST_DRAIN;
                    // The fall before the first data rise must keep the freshly loaded MSB.
                    end else if (sclk_fall && bit_cnt_q > CNT_W'(CMD_W)) begin
                        sout_d = {sout_q[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DRAIN: begin
                    if (sclk_rise) bit_cnt_d = bit_cnt_inc;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (commit_q) begin
            if (bit_cnt_q != CNT_W'(FRAME_W)) begin
                err_len_d = 1'b1;
            end else if (!in_range(commit_addr)) begin
                err_addr_d = 1'b1;
            end else if (cmd_sr_q[CMD_W-1]) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (commit_addr == ADDR_W'(i)) bank_d[i] = wdata_sr_q;
                end
                wr_stb_d  = 1'b1;
                wr_addr_d = commit_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            wdata_sr_q  <= '0;
            sout_q      <= '0;
            cipo_oe_q   <= 1'b0;
            commit_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) bank_q[i] <= RESET_VAL;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            rd_stb_q    <= 1'b0;
            err_len_q   <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            copi_sync_q <= copi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            wdata_sr_q  <= wdata_sr_d;
            sout_q      <= sout_d;
            cipo_oe_q   <= cipo_oe_d;
            commit_q    <= commit_d;
            bank_q      <= bank_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            rd_stb_q    <= rd_stb_d;
            err_len_q   <= err_len_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_comb begin
        regs_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i*DATA_W +: DATA_W] = bank_q[i];
    end

    assign spi.cipo    = cipo_oe_q & sout_q[DATA_W-1];
    assign spi.cipo_oe = cipo_oe_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign rd_stb      = rd_stb_q;
    assign err_len     = err_len_q;
    assign err_addr    = err_addr_q;
endmodule
